// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash values, FSM encoding
// and the FIPS 180-4 bit-mixing helpers.
`default_nettype none

package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: a..h plus W[t], K[t] -> next a..h.
`default_nettype none

module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] f_i,
    input  logic [31:0] g_i,
    input  logic [31:0] h_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o,
    output logic [31:0] f_o,
    output logic [31:0] g_o,
    output logic [31:0] h_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1  = h_i + bsig1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
    assign t2  = bsig0(a_i) + maj(a_i, b_i, c_i);

    assign a_o = t1 + t2;
    assign b_o = a_i;
    assign c_o = b_i;
    assign d_o = c_i;
    assign e_o = d_i + t1;
    assign f_o = e_i;
    assign g_o = f_i;
    assign h_o = g_i;

endmodule

`default_nettype wire

// File: rtl/sha256.sv
// Single-block SHA-256 engine: one round per clock, fixed 65-cycle latency from
// the accepting Start edge to DigestReady.
`default_nettype none

module sha256
    import sha256_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [511:0] Chunk,
    output logic [255:0] Digest,
    output logic         DigestReady
);

    state_t       state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    word_t        w_q [16];
    word_t        w_d [16];
    word_t        hv_q [8];
    word_t        hv_d [8];
    word_t        rnd [8];
    word_t        w_new;
    logic [255:0] digest_q, digest_d;
    logic         ready_q, ready_d;

    sha256_round u_round (
        .a_i (hv_q[0]),
        .b_i (hv_q[1]),
        .c_i (hv_q[2]),
        .d_i (hv_q[3]),
        .e_i (hv_q[4]),
        .f_i (hv_q[5]),
        .g_i (hv_q[6]),
        .h_i (hv_q[7]),
        .w_i (w_q[0]),
        .k_i (K[cnt_q[5:0]]),
        .a_o (rnd[0]),
        .b_o (rnd[1]),
        .c_o (rnd[2]),
        .d_o (rnd[3]),
        .e_o (rnd[4]),
        .f_o (rnd[5]),
        .g_o (rnd[6]),
        .h_o (rnd[7])
    );

    // Window holds W[t..t+15]; this is W[t+16], shifted in behind the consumed W[t].
    assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digest_d = digest_q;
        ready_d  = ready_q;
        for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
        for (int i = 0; i < 8; i++)  hv_d[i] = hv_q[i];

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    for (int i = 0; i < 16; i++) w_d[i] = Chunk[511 - 32*i -: 32];
                    for (int i = 0; i < 8; i++)  hv_d[i] = IV[i];
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // Counter value 64 marks the extra finalisation edge after round 63.
                if (cnt_q[6]) begin
                    for (int i = 0; i < 8; i++) digest_d[255 - 32*i -: 32] = IV[i] + hv_q[i];
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    for (int i = 0; i < 8; i++)  hv_d[i] = rnd[i];
                    for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
                    w_d[15] = w_new;
                    cnt_d   = cnt_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digest_q <= '0;
            ready_q  <= 1'b0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            for (int i = 0; i < 8; i++)  hv_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digest_q <= digest_d;
            ready_q  <= ready_d;
            for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
            for (int i = 0; i < 8; i++)  hv_q[i] <= hv_d[i];
        end
    end

    assign Digest      = digest_q;
    assign DigestReady = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256.sv
// Self-checking bench for sha256: directed vectors plus random blocks against a
// straightforward FIPS 180-4 single-block model.
`default_nettype none

module tb_sha256;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [511:0] Chunk;
    logic [255:0] Digest;
    logic         DigestReady;

    int nvec = 0;
    int nerr = 0;

    logic [255:0] last_dig;

    localparam logic [255:0] EMPTY_D =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] ABC_D =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] EMPTY_C = {32'h80000000, 480'd0};
    localparam logic [511:0] ABC_C   = {32'h61626380, 448'd0, 32'h00000018};

    sha256 dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Chunk       (Chunk),
        .Digest      (Digest),
        .DigestReady (DigestReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [31:0] MK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] MIV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_hash(input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = MIV[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + MK[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = MIV[i] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_chunk();
        logic [511:0] c;
        for (int i = 0; i < 16; i++) c[32*i +: 32] = $urandom;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Hash one block with a 1-cycle Start pulse; Chunk is scrambled right after capture.
    // repulse_at >= 0 re-asserts Start (with other data) just before that round's edge.
    task automatic run_hash(input string tag, input logic [511:0] c, input logic [255:0] exp,
                            input int repulse_at);
        int bad;
        bad = 0;
        @(negedge Clk);
        Start = 1'b1;
        Chunk = c;
        @(posedge Clk); #1;
        Start = 1'b0;
        Chunk = rand_chunk();
        chk({tag, "_rdy_clr"}, {255'd0, DigestReady}, 256'd0);
        for (int e = 1; e <= 64; e++) begin
            if (repulse_at >= 0 && e == repulse_at + 1) begin
                Start = 1'b1;
                Chunk = rand_chunk();
            end
            @(posedge Clk); #1;
            Start = 1'b0;
            if (DigestReady !== 1'b0 || Digest !== last_dig) bad++;
        end
        chk({tag, "_busy"}, 256'(bad), 256'd0);
        @(posedge Clk); #1;
        chk({tag, "_rdy"}, {255'd0, DigestReady}, 256'd1);
        chk({tag, "_dig"}, Digest, exp);
        last_dig = exp;
    endtask

    initial begin
        logic [511:0] cx, cy;
        Reset = 1'b0;
        Start = 1'b0;
        Chunk = '0;
        last_dig = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_dig", Digest, 256'd0);
        chk("reset_rdy", {255'd0, DigestReady}, 256'd0);
        @(negedge Clk);
        Reset = 1'b1;

        run_hash("empty", EMPTY_C, EMPTY_D, -1);
        run_hash("abc", ABC_C, ABC_D, -1);

        // Digest and DigestReady hold in DONE.
        repeat (3) @(posedge Clk);
        #1;
        chk("hold_dig", Digest, ABC_D);
        chk("hold_rdy", {255'd0, DigestReady}, 256'd1);

        for (int k = 0; k < 8; k++) begin
            cx = rand_chunk();
            run_hash($sformatf("b2b%0d", k), cx, ref_hash(cx), -1);
        end

        cx = rand_chunk();
        run_hash("repulse30", cx, ref_hash(cx), 30);

        // Start held high restarts at the first DONE edge with the then-current Chunk.
        cx = rand_chunk();
        cy = rand_chunk();
        @(negedge Clk);
        Start = 1'b1;
        Chunk = cx;
        @(posedge Clk); #1;
        Chunk = cy;
        repeat (65) @(posedge Clk);
        #1;
        chk("held_rdy1", {255'd0, DigestReady}, 256'd1);
        chk("held_dig1", Digest, ref_hash(cx));
        @(posedge Clk); #1;
        Start = 1'b0;
        Chunk = rand_chunk();
        chk("held_rdy_clr", {255'd0, DigestReady}, 256'd0);
        chk("held_dig_keep", Digest, ref_hash(cx));
        repeat (65) @(posedge Clk);
        #1;
        chk("held_rdy2", {255'd0, DigestReady}, 256'd1);
        chk("held_dig2", Digest, ref_hash(cy));

        // Reset during round 40 aborts immediately; Start is ignored while in reset.
        @(negedge Clk);
        Start = 1'b1;
        Chunk = rand_chunk();
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (40) @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_dig", Digest, 256'd0);
        chk("abort_rdy", {255'd0, DigestReady}, 256'd0);
        Start = 1'b1;
        Chunk = rand_chunk();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        Start = 1'b0;
        repeat (70) @(posedge Clk);
        #1;
        chk("idle_rdy", {255'd0, DigestReady}, 256'd0);
        chk("idle_dig", Digest, 256'd0);
        last_dig = '0;
        run_hash("abc_after_rst", ABC_C, ABC_D, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
